// File: rtl/mul_share_arbiter.sv
// Round-robin share of one multi-cycle 64-bit multiplier between two requesters.
// Operands are held on mul_a/mul_b from accept until the response is taken.
module mul_share_arbiter #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [63:0]      req_a0,
  input  logic [63:0]      req_b0,
  input  logic [63:0]      req_a1,
  input  logic [63:0]      req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [63:0]      resp_product,
  output logic [63:0]      mul_a,
  output logic [63:0]      mul_b,
  input  logic [63:0]      mul_product,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int LAT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        mul_a_q, mul_a_d;
  logic [63:0]        mul_b_q, mul_b_d;
  logic [63:0]        resp_product_q, resp_product_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  logic               grant_vld;
  logic               grant_id;

  // Contention goes to whoever was not served last.
  always_comb begin
    grant_vld = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant_q;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    resp_product_d = resp_product_q;
    ops_done_d     = ops_done_q;
    req_ready      = 2'b00;
    resp_valid     = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_id] = 1'b1;
          mul_a_d = grant_id ? req_a1 : req_a0;
          mul_b_d = grant_id ? req_b1 : req_b0;
          owner_d = grant_id;
          cnt_d   = LAT_W'(MUL_LATENCY - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          resp_product_d = mul_product;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          last_grant_d = owner_q;
          ops_done_d   = ops_done_q + CNT_W'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      resp_product_q <= '0;
      ops_done_q     <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      resp_product_q <= resp_product_d;
      ops_done_q     <= ops_done_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign resp_product = resp_product_q;
  assign ops_done     = ops_done_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a combinational multiplier model.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [63:0] resp_product;
  logic [63:0] mul_a, mul_b;
  logic [63:0] mul_product;
  logic        busy;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  assign mul_product = mul_a * mul_b;

  mul_share_arbiter #(.MUL_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_product(resp_product),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_product"}, resp_product, 64'd0);
    chk({tag, "_mul_a"}, mul_a, 64'd0);
    chk({tag, "_mul_b"}, mul_b, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ops_done"}, 64'(ops_done), 64'd0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    exp_ops = 0;
  endtask

  // One full transaction; inputs for the expected owner must already be driven.
  task automatic txn(input int own, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input bit drop, input int hold);
    logic [1:0] oh;
    int n;
    oh = (own == 0) ? 2'b01 : 2'b10;
    n  = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 64'(req_ready), 64'(oh));
    @(negedge clk);
    if (drop) req_valid[own] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("busy_phase", {59'd0, busy, resp_valid, req_ready}, 64'b10000);
      chk("busy_mul_a", mul_a, a);
      @(negedge clk);
    end
    chk("resp_valid", 64'(resp_valid), 64'(oh));
    chk("resp_product", resp_product, exp);
    for (int k = 0; k < hold; k++) begin
      resp_ready = (k % 2 == 1) ? ~oh : 2'b00;
      @(negedge clk);
      chk("hold_resp_valid", 64'(resp_valid), 64'(oh));
      chk("hold_resp_product", resp_product, exp);
      chk("hold_mul_a", mul_a, a);
      chk("hold_mul_b", mul_b, b);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = oh;
    @(negedge clk);
    resp_ready = 2'b00;
    exp_ops++;
    chk("resp_drop", 64'(resp_valid), 64'd0);
    chk("ops_done", 64'(ops_done), 64'(exp_ops));
  endtask

  initial begin
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    do_reset();
    check_reset_state("rst");

    // Single requester, product 49, ready in the same cycle as valid
    req_a0 = 64'd7; req_b0 = 64'd7; req_valid = 2'b01;
    #1;
    chk("t1_same_cycle_ready", 64'(req_ready), 64'b01);
    txn(0, 64'd7, 64'd7, 64'd49, 1'b1, 0);

    // Tie after reset: requester 0 first, then 1
    do_reset();
    req_a0 = 64'd3; req_b0 = 64'd5; req_a1 = 64'd6; req_b1 = 64'd9;
    req_valid = 2'b11;
    txn(0, 64'd3, 64'd5, 64'd15, 1'b1, 0);
    txn(1, 64'd6, 64'd9, 64'd54, 1'b1, 0);

    // Continuous contention alternates grants
    do_reset();
    req_a0 = 64'd2; req_b0 = 64'd3; req_a1 = 64'd4; req_b1 = 64'd5;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) txn(0, 64'd2, 64'd3, 64'd6, 1'b0, 0);
      else            txn(1, 64'd4, 64'd5, 64'd20, 1'b0, 0);
    end
    chk("t3_ops_done_6", 64'(ops_done), 64'd6);
    req_valid = 2'b00;

    // Negative operand passes through untouched: 5 * -6 = -30
    req_a0 = 64'd5; req_b0 = {32'hFFFFFFFF, ~32'd5}; req_valid = 2'b01;
    txn(0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFE2, 1'b1, 0);

    // Stalled response with req0 waiting and non-owner resp_ready pulses
    req_a0 = 64'd2;  req_b0 = 64'd21;
    req_a1 = 64'd11; req_b1 = 64'd13;
    req_valid = 2'b11;
    txn(1, 64'd11, 64'd13, 64'd143, 1'b1, 10);
    txn(0, 64'd2, 64'd21, 64'd42, 1'b1, 0);
    chk("t5_ops_done", 64'(ops_done), 64'd9);

    // Reset two cycles into BUSY abandons the op
    req_a0 = 64'd9; req_b0 = 64'd9; req_valid = 2'b01;
    #1;
    chk("t6_grant", 64'(req_ready), 64'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("t6_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    check_reset_state("t6_rst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_resp", {62'd0, resp_valid}, 64'd0);
    end
    req_a0 = 64'd10; req_b0 = 64'd10; req_valid = 2'b01;
    txn(0, 64'd10, 64'd10, 64'd100, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
